// File: rtl/rotor_pkg.sv
// Shared encodings for the rotary-encoder stimulus generator.
package rotor_pkg;

   typedef logic [1:0] op_t;
   localparam op_t OP_NOP   = 2'd0;
   localparam op_t OP_LEFT  = 2'd1;
   localparam op_t OP_RIGHT = 2'd2;
   localparam op_t OP_PRESS = 2'd3;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_PH1      = 3'd1;
   localparam state_t ST_PH2      = 3'd2;
   localparam state_t ST_PH3      = 3'd3;
   localparam state_t ST_PH4      = 3'd4;
   localparam state_t ST_PRESS_HI = 3'd5;
   localparam state_t ST_PRESS_LO = 3'd6;
   localparam state_t ST_FIN      = 3'd7;

   localparam logic IDLE_AB     = 1'b1;
   localparam logic IDLE_CENTER = 1'b0;

   // {A, B} levels of the selected channel for a given op and state. The leading line is A for
   // LEFT and B for RIGHT; anything outside PH1..PH3 sits at the idle (high) level.
   function automatic logic [1:0] ab_levels(op_t op, state_t st);
      logic lead;
      logic trail;
      lead  = IDLE_AB;
      trail = IDLE_AB;
      case (st)
         ST_PH1:  lead = 1'b0;
         ST_PH2:  begin
            lead  = 1'b0;
            trail = 1'b0;
         end
         ST_PH3:  trail = 1'b0;
         default: ;
      endcase
      if (op == OP_LEFT) begin
         return {lead, trail};
      end else if (op == OP_RIGHT) begin
         return {trail, lead};
      end
      return {IDLE_AB, IDLE_AB};
   endfunction

endpackage

// File: rtl/rotor_phase_timer.sv
// Phase duration down-counter; expire_o marks the last cycle of the loaded duration.
module rotor_phase_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload on strobe, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A value of one means this is the final cycle of the phase.
   assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rotor_quad_gen.sv
// Multi-channel rotary encoder waveform generator driven by turn/press commands.
module rotor_quad_gen
   import rotor_pkg::*;
#(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned STEPS_W   = 8,
   parameter int unsigned T_LEAD    = 250,
   parameter int unsigned T_BOTH    = 300,
   parameter int unsigned T_TRAIL   = 50,
   parameter int unsigned T_REST    = 500,
   parameter int unsigned T_PRESS   = 400,
   parameter int unsigned T_RELEASE = 200,
   localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [1:0]         CMD_OP,
   input  logic [CH_W-1:0]    CMD_CH,
   input  logic [STEPS_W-1:0] CMD_STEPS,
   input  logic               ABORT,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR,
   output logic [N_CH-1:0]    ROT_A,
   output logic [N_CH-1:0]    ROT_B,
   output logic [N_CH-1:0]    ROT_CENTER
);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [STEPS_W-1:0] steps_q, steps_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [N_CH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
   logic [N_CH-1:0]    sel;
   logic [1:0]         ab;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_expire;

   rotor_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   // Command acceptance, phase sequencing and step counting.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      ch_d     = ch_q;
      steps_d  = steps_q;
      err_d    = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               op_d    = CMD_OP;
               ch_d    = CMD_CH;
               steps_d = CMD_STEPS;
               if (32'(CMD_CH) >= N_CH) begin
                  state_d = ST_FIN;
                  err_d   = 1'b1;
               end else if (CMD_OP == OP_NOP || CMD_STEPS == '0) begin
                  state_d = ST_FIN;
               end else if (CMD_OP == OP_PRESS) begin
                  state_d  = ST_PRESS_HI;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(T_PRESS);
               end else begin
                  state_d  = ST_PH1;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(T_LEAD);
               end
            end
         end
         ST_PH1: if (tmr_expire) begin
            state_d  = ST_PH2;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_BOTH);
         end
         ST_PH2: if (tmr_expire) begin
            state_d  = ST_PH3;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_TRAIL);
         end
         ST_PH3: if (tmr_expire) begin
            state_d  = ST_PH4;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_REST);
         end
         ST_PH4: if (tmr_expire) begin
            if (steps_q == STEPS_W'(1)) begin
               state_d = ST_FIN;
            end else begin
               steps_d  = steps_q - STEPS_W'(1);
               state_d  = ST_PH1;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(T_LEAD);
            end
         end
         ST_PRESS_HI: if (tmr_expire) begin
            state_d  = ST_PRESS_LO;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_RELEASE);
         end
         ST_PRESS_LO: if (tmr_expire) begin
            if (steps_q == STEPS_W'(1)) begin
               state_d = ST_FIN;
            end else begin
               steps_d  = steps_q - STEPS_W'(1);
               state_d  = ST_PRESS_HI;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(T_PRESS);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // FIN already ends the command, so an abort there would only duplicate DONE.
      if (ABORT && state_q != ST_IDLE && state_q != ST_FIN) begin
         state_d  = ST_FIN;
         err_d    = 1'b1;
         tmr_load = 1'b0;
      end
      done_d = (state_d == ST_FIN);
   end

   // Next output levels follow the next state so the pins change on the same edge as the FSM.
   always_comb begin
      ab  = ab_levels(op_d, state_d);
      a_d = {N_CH{IDLE_AB}};
      b_d = {N_CH{IDLE_AB}};
      c_d = {N_CH{IDLE_CENTER}};
      for (int unsigned i = 0; i < N_CH; i++) begin
         sel[i] = (32'(ch_d) == i);
         if (sel[i]) begin
            a_d[i] = ab[1];
            b_d[i] = ab[0];
            c_d[i] = (state_d == ST_PRESS_HI);
         end
      end
   end

   // State, command latch and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         ch_q    <= '0;
         steps_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         a_q     <= {N_CH{IDLE_AB}};
         b_q     <= {N_CH{IDLE_AB}};
         c_q     <= {N_CH{IDLE_CENTER}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ch_q    <= ch_d;
         steps_q <= steps_d;
         done_q  <= done_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   assign CMD_READY  = (state_q == ST_IDLE);
   assign BUSY       = !CMD_READY;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign ROT_A      = a_q;
   assign ROT_B      = b_q;
   assign ROT_CENTER = c_q;

endmodule

// File: tb/tb_rotor_quad_gen.sv
// Scoreboard bench: the driver queues expected per-cycle outputs, the monitor checks them.
module tb_rotor_quad_gen;
   import rotor_pkg::*;

   localparam int unsigned NCH       = 3;
   localparam int unsigned T_LEAD    = 2;
   localparam int unsigned T_BOTH    = 3;
   localparam int unsigned T_TRAIL   = 1;
   localparam int unsigned T_REST    = 4;
   localparam int unsigned T_PRESS   = 3;
   localparam int unsigned T_RELEASE = 2;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] c;
      logic       done;
      logic       err;
   } exp_t;

   logic       CLK;
   logic       RST_N;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic [1:0] CMD_CH;
   logic [7:0] CMD_STEPS;
   logic       ABORT;
   logic       BUSY;
   logic       DONE;
   logic       ERR;
   logic [2:0] ROT_A;
   logic [2:0] ROT_B;
   logic [2:0] ROT_CENTER;

   exp_t exp_q[$];
   exp_t trace[$];
   int   tests = 0;
   int   fails = 0;

   rotor_quad_gen #(
      .N_CH      (NCH),
      .CNT_W     (16),
      .STEPS_W   (8),
      .T_LEAD    (T_LEAD),
      .T_BOTH    (T_BOTH),
      .T_TRAIL   (T_TRAIL),
      .T_REST    (T_REST),
      .T_PRESS   (T_PRESS),
      .T_RELEASE (T_RELEASE)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .CMD_VALID  (CMD_VALID),
      .CMD_READY  (CMD_READY),
      .CMD_OP     (CMD_OP),
      .CMD_CH     (CMD_CH),
      .CMD_STEPS  (CMD_STEPS),
      .ABORT      (ABORT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR),
      .ROT_A      (ROT_A),
      .ROT_B      (ROT_B),
      .ROT_CENTER (ROT_CENTER)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic exp_t idle_e();
      exp_t e;
      e.a    = 3'b111;
      e.b    = 3'b111;
      e.c    = 3'b000;
      e.done = 1'b0;
      e.err  = 1'b0;
      return e;
   endfunction

   // Reference model: expand a command into its expected busy-cycle trace, FIN cycle included.
   task automatic gen_trace(input logic [1:0] op, input int ch, input int steps);
      logic lead  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic trail [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   dur   [4];
      exp_t e;
      dur = '{int'(T_LEAD), int'(T_BOTH), int'(T_TRAIL), int'(T_REST)};
      trace.delete();
      if (ch >= int'(NCH)) begin
         e = idle_e(); e.done = 1'b1; e.err = 1'b1;
         trace.push_back(e);
         return;
      end
      for (int s = 0; s < steps && op != OP_NOP; s++) begin
         if (op == OP_PRESS) begin
            repeat (T_PRESS) begin
               e = idle_e(); e.c[ch] = 1'b1;
               trace.push_back(e);
            end
            repeat (T_RELEASE) trace.push_back(idle_e());
         end else begin
            for (int p = 0; p < 4; p++) begin
               repeat (dur[p]) begin
                  e = idle_e();
                  e.a[ch] = (op == OP_LEFT) ? lead[p] : trail[p];
                  e.b[ch] = (op == OP_LEFT) ? trail[p] : lead[p];
                  trace.push_back(e);
               end
            end
         end
      end
      e = idle_e(); e.done = 1'b1;
      trace.push_back(e);
   endtask

   // Monitor: one expected entry per busy cycle, idle levels otherwise.
   initial begin
      exp_t act;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            act = {ROT_A, ROT_B, ROT_CENTER, DONE, ERR};
            tests++;
            if (BUSY) begin
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL busy_extra: got a/b/c/done/err=%b no cycle expected", act);
               end else begin
                  e = exp_q.pop_front();
                  if (act !== e) begin
                     fails++;
                     $display("FAIL busy_cycle @%0t: got a=%b b=%b c=%b done=%b err=%b, want a=%b b=%b c=%b done=%b err=%b",
                              $time, act.a, act.b, act.c, act.done, act.err,
                              e.a, e.b, e.c, e.done, e.err);
                  end
               end
            end else if (act !== idle_e()) begin
               fails++;
               $display("FAIL idle_levels @%0t: got a=%b b=%b c=%b done=%b err=%b, want 111 111 000 0 0",
                        $time, act.a, act.b, act.c, act.done, act.err);
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge CLK);
      while (!CMD_READY && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (!CMD_READY) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: CMD_READY=%b after %0d cycles, want 1", CMD_READY, n);
      end
   endtask

   task automatic check_drain(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d expected cycles left unconsumed, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Queue the expected trace (truncated at abort_at if nonzero), then drive the command.
   task automatic issue(input logic [1:0] op, input int ch, input int steps, input int abort_at);
      exp_t e;
      wait_ready();
      gen_trace(op, ch, steps);
      if (abort_at > 0 && abort_at < trace.size()) begin
         while (trace.size() > abort_at) void'(trace.pop_back());
         e = idle_e(); e.done = 1'b1; e.err = 1'b1;
         trace.push_back(e);
      end else begin
         abort_at = 0;
      end
      foreach (trace[i]) exp_q.push_back(trace[i]);
      CMD_OP    = op;
      CMD_CH    = 2'(ch);
      CMD_STEPS = 8'(steps);
      CMD_VALID = 1'b1;
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at - 1) @(posedge CLK);
         #1 ABORT = 1'b1;
         @(posedge CLK);
         #1 ABORT = 1'b0;
      end
      wait_ready();
      check_drain("cmd");
   endtask

   initial begin
      exp_t act;
      RST_N     = 1'b0;
      CMD_VALID = 1'b0;
      CMD_OP    = OP_NOP;
      CMD_CH    = 2'd0;
      CMD_STEPS = 8'd0;
      ABORT     = 1'b0;
      #12;
      act = {ROT_A, ROT_B, ROT_CENTER, DONE, ERR};
      tests++;
      if (act !== idle_e() || CMD_READY !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: got a=%b b=%b c=%b done=%b ready=%b, want 111 111 000 0 1",
                  act.a, act.b, act.c, act.done, CMD_READY);
      end
      @(posedge CLK);
      #1 RST_N = 1'b1;

      // Directed commands.
      issue(OP_LEFT,  1, 2, 0);
      issue(OP_RIGHT, 0, 1, 0);
      issue(OP_PRESS, 2, 1, 0);
      issue(OP_LEFT,  3, 2, 0);
      issue(OP_RIGHT, 1, 0, 0);
      issue(OP_NOP,   0, 3, 0);
      issue(OP_LEFT,  0, 1, 4);
      issue(OP_PRESS, 1, 3, 7);

      // Abort while idle must be ignored.
      wait_ready();
      ABORT = 1'b1;
      @(posedge CLK);
      #1 ABORT = 1'b0;
      repeat (2) @(posedge CLK);

      // Back-to-back: VALID stays high across both commands.
      wait_ready();
      gen_trace(OP_LEFT, 2, 1);
      foreach (trace[i]) exp_q.push_back(trace[i]);
      gen_trace(OP_PRESS, 0, 2);
      foreach (trace[i]) exp_q.push_back(trace[i]);
      CMD_OP = OP_LEFT; CMD_CH = 2'd2; CMD_STEPS = 8'd1; CMD_VALID = 1'b1;
      @(posedge CLK);
      #1 CMD_OP = OP_PRESS; CMD_CH = 2'd0; CMD_STEPS = 8'd2;
      wait_ready();
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
      wait_ready();
      check_drain("b2b");

      // Reset in the middle of a command: immediate idle, no DONE.
      wait_ready();
      gen_trace(OP_LEFT, 0, 2);
      foreach (trace[i]) exp_q.push_back(trace[i]);
      CMD_OP = OP_LEFT; CMD_CH = 2'd0; CMD_STEPS = 8'd2; CMD_VALID = 1'b1;
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
      repeat (5) @(posedge CLK);
      #1 exp_q.delete();
      RST_N = 1'b0;
      #1;
      act = {ROT_A, ROT_B, ROT_CENTER, DONE, ERR};
      tests++;
      if (act !== idle_e() || CMD_READY !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid: got a=%b b=%b c=%b done=%b ready=%b, want 111 111 000 0 1",
                  act.a, act.b, act.c, act.done, CMD_READY);
      end
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;

      // Randomised commands, some aborted partway.
      for (int k = 0; k < 30; k++) begin
         int op;
         int ch;
         int st;
         int ab;
         op = $urandom_range(0, 3);
         ch = $urandom_range(0, 3);
         st = $urandom_range(0, 3);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
         issue(2'(op), ch, st, ab);
      end

      repeat (3) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
